// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit path.
package udp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } udp_arb_state_t;

  localparam logic [15:0] UDP_HDR_LENGTH = 16'h8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: first requester after last_grant wins.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_any
);

  logic [NUM_PORTS-1:0] rot;

  // Rotating the doubled request vector puts last_grant+1 at bit 0.
  always_comb begin
    rot       = NUM_PORTS'({req, req} >> (int'(last_grant) + 1));
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!grant_any && rot[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'((int'(last_grant) + 1 + k) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin scheduler sharing one udp_tx encapsulator between NUM_PORTS
// requesters; the grant is held from header acceptance through payload tlast.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int AXI_DATA_WIDTH = 8,
  localparam int IDX_W = $clog2(NUM_PORTS)
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic [NUM_PORTS-1:0]                s_udp_hdr_tvalid,
  output logic [NUM_PORTS-1:0]                s_udp_hdr_trdy,
  input  logic [16*NUM_PORTS-1:0]             s_udp_src_port,
  input  logic [16*NUM_PORTS-1:0]             s_udp_dst_port,
  input  logic [16*NUM_PORTS-1:0]             s_udp_hdr_checksum,
  input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  output logic [NUM_PORTS-1:0]                s_axis_trdy,
  output logic                                m_udp_hdr_tvalid,
  input  logic                                m_udp_hdr_trdy,
  output logic [15:0]                         m_udp_src_port,
  output logic [15:0]                         m_udp_dst_port,
  output logic [15:0]                         m_udp_hdr_checksum,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_trdy,
  output logic                                o_grant_valid,
  output logic [IDX_W-1:0]                    o_grant_idx,
  output logic                                o_proto_err
);

  udp_arb_state_t state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  logic                      hdr_phase;
  logic                      pay_phase;
  logic                      sel_hdr_valid;
  logic [15:0]               sel_src;
  logic [15:0]               sel_dst;
  logic [15:0]               sel_csum;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic                      sel_axis_valid;
  logic                      sel_last;
  logic                      hdr_hs;
  logic                      last_beat;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_arbiter (
    .req        (s_udp_hdr_tvalid),
    .last_grant (last_grant),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  assign hdr_phase     = (state == HDR);
  assign pay_phase     = (state != IDLE);
  assign hdr_hs        = m_udp_hdr_tvalid & m_udp_hdr_trdy;
  assign last_beat     = m_axis_tvalid & m_axis_trdy & m_axis_tlast;
  assign o_grant_valid = pay_phase;
  assign o_grant_idx   = grant_idx;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      last_grant  <= IDX_W'(NUM_PORTS - 1);
      o_proto_err <= 1'b0;
    end else begin
      o_proto_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            state     <= HDR;
          end
        end
        HDR: begin
          // A packet ending before its header is taken is abandoned as an error.
          if (last_beat) begin
            o_proto_err <= 1'b1;
            last_grant  <= grant_idx;
            state       <= IDLE;
          end else if (hdr_hs) begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (last_beat) begin
            last_grant <= grant_idx;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sel_hdr_valid  = 1'b0;
    sel_src        = '0;
    sel_dst        = '0;
    sel_csum       = '0;
    sel_data       = '0;
    sel_axis_valid = 1'b0;
    sel_last       = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_hdr_valid  = s_udp_hdr_tvalid[i];
        sel_src        = s_udp_src_port[16*i +: 16];
        sel_dst        = s_udp_dst_port[16*i +: 16];
        sel_csum       = s_udp_hdr_checksum[16*i +: 16];
        sel_data       = s_axis_tdata[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH];
        sel_axis_valid = s_axis_tvalid[i];
        sel_last       = s_axis_tlast[i];
      end
    end
  end

  // Header fields read as zero whenever no header is being offered.
  always_comb begin
    m_udp_hdr_tvalid   = hdr_phase & sel_hdr_valid;
    m_udp_src_port     = m_udp_hdr_tvalid ? sel_src  : 16'h0;
    m_udp_dst_port     = m_udp_hdr_tvalid ? sel_dst  : 16'h0;
    m_udp_hdr_checksum = m_udp_hdr_tvalid ? sel_csum : 16'h0;
    m_axis_tvalid      = pay_phase & sel_axis_valid;
    m_axis_tdata       = pay_phase ? sel_data : '0;
    m_axis_tlast       = pay_phase & sel_last;
  end

  always_comb begin
    s_udp_hdr_trdy = '0;
    s_axis_trdy    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        s_udp_hdr_trdy[i] = hdr_phase & m_udp_hdr_trdy;
        s_axis_trdy[i]    = pay_phase & m_axis_trdy;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: directed cycle table plus randomized
// traffic against a packet-level round-robin model.
module tb_udp_tx_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;

  logic           i_clk;
  logic           i_reset_n;
  logic [NP-1:0]  s_udp_hdr_tvalid;
  logic [NP-1:0]  s_udp_hdr_trdy;
  logic [16*NP-1:0] s_udp_src_port;
  logic [16*NP-1:0] s_udp_dst_port;
  logic [16*NP-1:0] s_udp_hdr_checksum;
  logic [DW*NP-1:0] s_axis_tdata;
  logic [NP-1:0]  s_axis_tvalid;
  logic [NP-1:0]  s_axis_tlast;
  logic [NP-1:0]  s_axis_trdy;
  logic           m_udp_hdr_tvalid;
  logic           m_udp_hdr_trdy;
  logic [15:0]    m_udp_src_port;
  logic [15:0]    m_udp_dst_port;
  logic [15:0]    m_udp_hdr_checksum;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_trdy;
  logic           o_grant_valid;
  logic [1:0]     o_grant_idx;
  logic           o_proto_err;

  udp_tx_arbiter #(
    .NUM_PORTS(NP),
    .AXI_DATA_WIDTH(DW)
  ) dut (
    .i_clk              (i_clk),
    .i_reset_n          (i_reset_n),
    .s_udp_hdr_tvalid   (s_udp_hdr_tvalid),
    .s_udp_hdr_trdy     (s_udp_hdr_trdy),
    .s_udp_src_port     (s_udp_src_port),
    .s_udp_dst_port     (s_udp_dst_port),
    .s_udp_hdr_checksum (s_udp_hdr_checksum),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_trdy        (s_axis_trdy),
    .m_udp_hdr_tvalid   (m_udp_hdr_tvalid),
    .m_udp_hdr_trdy     (m_udp_hdr_trdy),
    .m_udp_src_port     (m_udp_src_port),
    .m_udp_dst_port     (m_udp_dst_port),
    .m_udp_hdr_checksum (m_udp_hdr_checksum),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_trdy        (m_axis_trdy),
    .o_grant_valid      (o_grant_valid),
    .o_grant_idx        (o_grant_idx),
    .o_proto_err        (o_proto_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // rst, hv, av, al, mht, mat | egv, egi, emhv, eht, eat, emav, emal, eerr
  typedef struct packed {
    logic       rst;
    logic [3:0] hv;
    logic [3:0] av;
    logic [3:0] al;
    logic       mht;
    logic       mat;
    logic       egv;
    logic [1:0] egi;
    logic       emhv;
    logic [3:0] eht;
    logic [3:0] eat;
    logic       emav;
    logic       emal;
    logic       eerr;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] p_src [NP];
  logic [15:0] p_dst [NP];
  logic [15:0] p_csum[NP];
  logic [7:0]  p_data[NP];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic driveBus();
    for (int i = 0; i < NP; i++) begin
      s_udp_src_port[16*i +: 16]     = p_src[i];
      s_udp_dst_port[16*i +: 16]     = p_dst[i];
      s_udp_hdr_checksum[16*i +: 16] = p_csum[i];
      s_axis_tdata[DW*i +: DW]       = p_data[i];
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    logic [47:0] exp_hdr;
    i_reset_n        = v.rst;
    s_udp_hdr_tvalid = v.hv;
    s_axis_tvalid    = v.av;
    s_axis_tlast     = v.al;
    m_udp_hdr_trdy   = v.mht;
    m_axis_trdy      = v.mat;
    driveBus();
    #4;
    exp_hdr = v.emhv ? {p_src[v.egi], p_dst[v.egi], p_csum[v.egi]} : 48'h0;
    checkOutput($sformatf("row%0d_gv", row), o_grant_valid, v.egv);
    checkOutput($sformatf("row%0d_gi", row), o_grant_idx, v.egi);
    checkOutput($sformatf("row%0d_mhv", row), m_udp_hdr_tvalid, v.emhv);
    checkOutput($sformatf("row%0d_hdr", row), {m_udp_src_port, m_udp_dst_port, m_udp_hdr_checksum}, exp_hdr);
    checkOutput($sformatf("row%0d_hrdy", row), s_udp_hdr_trdy, v.eht);
    checkOutput($sformatf("row%0d_ardy", row), s_axis_trdy, v.eat);
    checkOutput($sformatf("row%0d_mav", row), m_axis_tvalid, v.emav);
    checkOutput($sformatf("row%0d_mal", row), m_axis_tlast, v.emal);
    checkOutput($sformatf("row%0d_data", row), m_axis_tdata, v.egv ? p_data[v.egi] : 8'h0);
    checkOutput($sformatf("row%0d_err", row), o_proto_err, v.eerr);
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyReset();
    i_reset_n        = 1'b0;
    s_udp_hdr_tvalid = '0;
    s_axis_tvalid    = '0;
    s_axis_tlast     = '0;
    m_udp_hdr_trdy   = 1'b0;
    m_axis_trdy      = 1'b0;
    driveBus();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  vec_t vecs[$];

  // Randomized-phase source and reference-model state
  logic       pend [NP];
  logic       hsent[NP];
  int         plen [NP];
  int         pbeat[NP];
  int         pseed[NP];
  logic [3:0] hv, av, al;
  logic       mht, mat;
  logic       mbusy, mhdr;
  logic [1:0] mgrant, mlast;

  initial begin
    for (int i = 0; i < NP; i++) begin
      p_src[i]  = 16'h1100 + 16'(i);
      p_dst[i]  = 16'h2200 + 16'(i);
      p_csum[i] = 16'h3300 + 16'(i);
      p_data[i] = 8'hA0 + 8'(i);
    end
    applyReset();

    // port 2 alone, 4-byte packet
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    // port 0 ends its payload while its header is still refused
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    // port 1 packet interrupted by reset on byte 3, then port 0 wins first
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0011, 4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0011, 4'b0011, 4'b0011, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 4'b0011, 4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});

    foreach (vecs[r]) applyStimulus(vecs[r], r);

    // Randomized traffic: sources hold requests until served, downstream
    // only takes payload once it has taken the header.
    applyReset();
    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0; hsent[i] = 1'b0; plen[i] = 1; pbeat[i] = 0; pseed[i] = 0;
    end
    mbusy = 1'b0; mhdr = 1'b0; mgrant = 2'd0; mlast = 2'd3;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]   = 1'b1;
          hsent[i]  = 1'b0;
          plen[i]   = int'($urandom_range(1, 5));
          pbeat[i]  = 0;
          pseed[i]  = int'($urandom_range(0, 255));
          p_src[i]  = 16'($urandom);
          p_dst[i]  = 16'($urandom);
          p_csum[i] = 16'($urandom);
        end
        hv[i]     = pend[i] & ~hsent[i];
        av[i]     = pend[i];
        al[i]     = pend[i] && (pbeat[i] == plen[i] - 1);
        p_data[i] = 8'(pseed[i] + pbeat[i] * 37);
      end
      mht = 1'($urandom_range(0, 1));
      mat = (mbusy && !mhdr) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_udp_hdr_tvalid = hv;
      s_axis_tvalid    = av;
      s_axis_tlast     = al;
      m_udp_hdr_trdy   = mht;
      m_axis_trdy      = mat;
      driveBus();
      #4;

      checkOutput("rnd_gv", o_grant_valid, mbusy);
      if (mbusy) checkOutput("rnd_gi", o_grant_idx, mgrant);
      checkOutput("rnd_mhv", m_udp_hdr_tvalid, mbusy && mhdr && hv[mgrant]);
      checkOutput("rnd_hdr", {m_udp_src_port, m_udp_dst_port, m_udp_hdr_checksum},
                  (mbusy && mhdr && hv[mgrant]) ? {p_src[mgrant], p_dst[mgrant], p_csum[mgrant]} : 48'h0);
      checkOutput("rnd_hrdy", s_udp_hdr_trdy, (mbusy && mhdr && mht) ? (4'b0001 << mgrant) : 4'b0000);
      checkOutput("rnd_ardy", s_axis_trdy, (mbusy && mat) ? (4'b0001 << mgrant) : 4'b0000);
      checkOutput("rnd_mav", m_axis_tvalid, mbusy && av[mgrant]);
      if (mbusy && av[mgrant]) begin
        checkOutput("rnd_data", m_axis_tdata, p_data[mgrant]);
        checkOutput("rnd_last", m_axis_tlast, al[mgrant]);
      end
      checkOutput("rnd_err", o_proto_err, 1'b0);

      if (!mbusy) begin
        if (hv != 4'b0000) begin
          for (int off = NP; off >= 1; off--) begin
            if (hv[(int'(mlast) + off) % NP]) mgrant = 2'((int'(mlast) + off) % NP);
          end
          mbusy = 1'b1;
          mhdr  = 1'b1;
        end
      end else begin
        if (mhdr && hv[mgrant] && mht) begin
          mhdr          = 1'b0;
          hsent[mgrant] = 1'b1;
        end
        if (av[mgrant] && mat) begin
          if (pbeat[mgrant] == plen[mgrant] - 1) begin
            pend[mgrant] = 1'b0;
            mbusy        = 1'b0;
            mlast        = mgrant;
          end else begin
            pbeat[mgrant]++;
          end
        end
      end
      @(posedge i_clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
